// File: rtl/cpu_stage_sequencer.sv
// cpu_stage_sequencer: steps SM510/SM5a instructions through fetch, decode, operand, execute and commit
module cpu_stage_sequencer #(
  parameter int ROM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic [3:0] cpu_id,
  input  logic [7:0] rom_data,
  input  logic       skip_req,
  input  logic       skip_lax_req,
  input  logic       halt_req,
  input  logic       wake,
  output logic [2:0] stage,
  output logic [7:0] opcode,
  output logic [7:0] last_opcode,
  output logic [7:0] operand,
  output logic       pc_inc,
  output logic       exec_en,
  output logic       commit_en,
  output logic       skipping,
  output logic       halted
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    FETCH2 = 3'd2,
    ARG    = 3'd3,
    EXEC   = 3'd4,
    COMMIT = 3'd5,
    HALT   = 3'd6
  } stage_e;
  localparam logic [1:0] LAT = ROM_LATENCY[1:0];
  stage_e     stage_q, stage_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] opcode_q, opcode_d, last_q, last_d, operand_q, operand_d;
  logic       skip_q, skip_d, pend_skip_q, pend_skip_d, pend_lax_q, pend_lax_d;
  logic       sm5a, two_byte, is_lax, en;
  assign sm5a     = cpu_id == 4'd4;
  assign two_byte = ~sm5a & (rom_data == 8'h5F || rom_data[7:4] == 4'h7);
  assign is_lax   = sm5a ? rom_data[7:4] == 4'h1 : rom_data[7:4] == 4'h2;
  assign en       = clk_en & reset_n;
  // Strobes are the action of the current stage, so they only exist on a tick
  assign pc_inc      = en & (stage_q == DECODE || stage_q == ARG);
  assign exec_en     = en & stage_q == EXEC & ~skip_q;
  assign commit_en   = en & stage_q == COMMIT;
  assign stage       = stage_q;
  assign opcode      = opcode_q;
  assign last_opcode = last_q;
  assign operand     = operand_q;
  assign skipping    = skip_q;
  assign halted      = stage_q == HALT;
  // Next-stage and latch logic; everything holds while the tick is low
  always_comb begin
    stage_d     = stage_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    last_d      = last_q;
    operand_d   = operand_q;
    skip_d      = skip_q;
    pend_skip_d = pend_skip_q;
    pend_lax_d  = pend_lax_q;
    if (clk_en) begin
      case (stage_q)
        FETCH, FETCH2: begin
          cnt_d = cnt_q == LAT ? 2'd0 : cnt_q + 2'd1;
          if (cnt_q == LAT) stage_d = stage_q == FETCH ? DECODE : ARG;
        end
        DECODE: begin
          opcode_d    = rom_data;
          last_d      = opcode_q;
          skip_d      = pend_skip_q | (pend_lax_q & is_lax);
          pend_skip_d = 1'b0;
          pend_lax_d  = 1'b0;
          stage_d     = two_byte ? FETCH2 : EXEC;
        end
        ARG: begin
          operand_d = rom_data;
          stage_d   = EXEC;
        end
        EXEC: begin
          pend_skip_d = skip_q ? pend_skip_q : skip_req;
          pend_lax_d  = skip_q ? pend_lax_q : skip_lax_req;
          stage_d     = halt_req && !skip_q ? HALT : COMMIT;
        end
        COMMIT: begin
          skip_d  = 1'b0;
          stage_d = FETCH;
        end
        HALT: stage_d = wake ? COMMIT : HALT;
        default: stage_d = FETCH;
      endcase
    end
  end
  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_q     <= FETCH;
      cnt_q       <= 2'd0;
      opcode_q    <= 8'h00;
      last_q      <= 8'h00;
      operand_q   <= 8'h00;
      skip_q      <= 1'b0;
      pend_skip_q <= 1'b0;
      pend_lax_q  <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      last_q      <= last_d;
      operand_q   <= operand_d;
      skip_q      <= skip_d;
      pend_skip_q <= pend_skip_d;
      pend_lax_q  <= pend_lax_d;
    end
  end
endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// tb_cpu_stage_sequencer: directed self-checking bench for the stage sequencer
module tb_cpu_stage_sequencer;
  logic       clk, reset_n, clk_en, skip_req, skip_lax_req, halt_req, wake;
  logic [3:0] cpu_id;
  logic [7:0] rom_data, opcode, last_opcode, operand;
  logic [2:0] stage;
  logic       pc_inc, exec_en, commit_en, skipping, halted;
  logic [7:0] rom [16];
  logic [3:0] pc;
  logic       pc_clr;
  int checks = 0;
  int errors = 0;

  cpu_stage_sequencer #(.ROM_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .cpu_id(cpu_id), .rom_data(rom_data),
    .skip_req(skip_req), .skip_lax_req(skip_lax_req), .halt_req(halt_req), .wake(wake),
    .stage(stage), .opcode(opcode), .last_opcode(last_opcode), .operand(operand),
    .pc_inc(pc_inc), .exec_en(exec_en), .commit_en(commit_en), .skipping(skipping), .halted(halted)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // External program counter and ROM driven by the sequencer's pc_inc strobe
  always @(posedge clk) pc <= pc_clr ? 4'd0 : pc + {3'd0, pc_inc};
  assign rom_data = rom[pc];

  task automatic rst();
    reset_n = 0; pc_clr = 1; clk_en = 1; cpu_id = 0;
    skip_req = 0; skip_lax_req = 0; halt_req = 0; wake = 0;
    @(negedge clk);
    reset_n = 1; pc_clr = 0;
  endtask

  task automatic run(input int n, output int pi, output int ex, output int cm, output int sk);
    pi = 0; ex = 0; cm = 0; sk = 0;
    repeat (n) begin
      #1;
      pi += int'(pc_inc); ex += int'(exec_en); cm += int'(commit_en); sk += int'(skipping);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int pi, ex, cm, sk;
    rst();
    #1;
    checks++; if (stage !== 3'd0 || opcode !== 8'h00 || last_opcode !== 8'h00 || operand !== 8'h00)
      begin errors++; $display("FAIL reset_state: stage=%0d op=%h last=%h opd=%h, want 0/00/00/00", stage, opcode, last_opcode, operand); end
    checks++; if ({pc_inc, exec_en, commit_en, skipping, halted} !== 5'b0)
      begin errors++; $display("FAIL reset_strobes: got %b want 00000", {pc_inc, exec_en, commit_en, skipping, halted}); end
    rom[0] = 8'h10; rom[1] = 8'h33;
    run(3, pi, ex, cm, sk);
    #1;
    checks++; if (stage !== 3'd4) begin errors++; $display("FAIL reset_pre_exec: stage=%0d want 4", stage); end
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    #1;
    checks++; if (stage !== 3'd0 || exec_en !== 1'b0 || opcode !== 8'h00)
      begin errors++; $display("FAIL reset_in_exec: stage=%0d exec_en=%b op=%h want 0/0/00", stage, exec_en, opcode); end
    @(negedge clk);
    run(2, pi, ex, cm, sk);
    #1;
    checks++; if (opcode !== 8'h33) begin errors++; $display("FAIL reset_resume_pc: op=%h want 33", opcode); end
  endtask

  task automatic test_single();
    int es[6] = '{0, 0, 1, 4, 5, 0};
    int ep[6] = '{0, 0, 1, 0, 0, 0};
    int ee[6] = '{0, 0, 0, 1, 0, 0};
    int ec[6] = '{0, 0, 0, 0, 1, 0};
    rst();
    rom[0] = 8'h20;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (int'(stage) != es[i] || int'(pc_inc) != ep[i] || int'(exec_en) != ee[i] || int'(commit_en) != ec[i])
        begin errors++; $display("FAIL single_cycle%0d: stage=%0d pi=%b ex=%b cm=%b want %0d/%0d/%0d/%0d", i, stage, pc_inc, exec_en, commit_en, es[i], ep[i], ee[i], ec[i]); end
      @(negedge clk);
    end
    #1;
    checks++; if (opcode !== 8'h20) begin errors++; $display("FAIL single_opcode: got %h want 20", opcode); end
  endtask

  task automatic test_two_byte();
    int pi, ex, cm, sk;
    rst();
    rom[0] = 8'h72; rom[1] = 8'h15;
    run(8, pi, ex, cm, sk);
    #1;
    checks++; if (pi != 2 || ex != 1 || cm != 1)
      begin errors++; $display("FAIL tl_strobes: pi=%0d ex=%0d cm=%0d want 2/1/1", pi, ex, cm); end
    checks++; if (stage !== 3'd0 || opcode !== 8'h72 || operand !== 8'h15)
      begin errors++; $display("FAIL tl_latch: stage=%0d op=%h opd=%h want 0/72/15", stage, opcode, operand); end
    rst();
    rom[0] = 8'h10; rom[1] = 8'h72; rom[2] = 8'h15; rom[3] = 8'h10;
    skip_req = 1;
    run(5, pi, ex, cm, sk);
    checks++; if (ex != 1) begin errors++; $display("FAIL skip_setter: ex=%0d want 1", ex); end
    run(8, pi, ex, cm, sk);
    checks++; if (pi != 2 || ex != 0 || cm != 1 || sk == 0)
      begin errors++; $display("FAIL tl_skipped: pi=%0d ex=%0d cm=%0d sk=%0d want 2/0/1/>0", pi, ex, cm, sk); end
    run(5, pi, ex, cm, sk);
    skip_req = 0;
    checks++; if (ex != 1 || sk != 0)
      begin errors++; $display("FAIL skip_no_chain: ex=%0d sk=%0d want 1/0", ex, sk); end
    checks++; if (pc !== 4'd4) begin errors++; $display("FAIL skip_pc: got %0d want 4", pc); end
  endtask

  task automatic test_decode_table();
    logic [3:0] ids[5] = '{4'd0, 4'd0, 4'd4, 4'd4, 4'd0};
    logic [7:0] ops[5] = '{8'h5F, 8'h72, 8'h72, 8'h5F, 8'h20};
    int         exp[5] = '{2, 2, 4, 4, 4};
    int pi, ex, cm, sk;
    for (int i = 0; i < 5; i++) begin
      rst();
      cpu_id = ids[i]; rom[0] = ops[i];
      run(3, pi, ex, cm, sk);
      #1;
      checks++; if (int'(stage) != exp[i])
        begin errors++; $display("FAIL decode_len%0d: id=%0d op=%h stage=%0d want %0d", i, ids[i], ops[i], stage, exp[i]); end
    end
    cpu_id = 0;
  endtask

  task automatic test_lax();
    int pi, ex, cm, sk;
    int ee[3] = '{1, 0, 1};
    int es[3] = '{0, 1, 0};
    rst();
    rom[0] = 8'h23; rom[1] = 8'h25; rom[2] = 8'h27;
    skip_lax_req = 1;
    for (int i = 0; i < 3; i++) begin
      run(5, pi, ex, cm, sk);
      checks++; if (ex != ee[i] || (sk != 0) != (es[i] != 0))
        begin errors++; $display("FAIL lax_run%0d: ex=%0d sk=%0d want ex=%0d skipping_seen=%0d", i, ex, sk, ee[i], es[i]); end
    end
    skip_lax_req = 0;
    #1;
    checks++; if (opcode !== 8'h27 || last_opcode !== 8'h25)
      begin errors++; $display("FAIL lax_last: op=%h last=%h want 27/25", opcode, last_opcode); end
  endtask

  task automatic test_halt();
    int pi, ex, cm, sk, bad;
    rst();
    rom[0] = 8'h10; rom[1] = 8'h11;
    halt_req = 1;
    run(3, pi, ex, cm, sk);
    #1;
    checks++; if (stage !== 3'd4 || exec_en !== 1'b1)
      begin errors++; $display("FAIL halt_exec: stage=%0d ex=%b want 4/1", stage, exec_en); end
    @(negedge clk);
    halt_req = 0;
    bad = 0;
    repeat (100) begin
      #1;
      if (halted !== 1'b1 || stage !== 3'd6 || (pc_inc | exec_en | commit_en) !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL halt_hold: %0d bad cycles want 0", bad); end
    wake = 1;
    @(negedge clk);
    wake = 0;
    #1;
    checks++; if (stage !== 3'd5 || commit_en !== 1'b1 || halted !== 1'b0)
      begin errors++; $display("FAIL halt_wake: stage=%0d cm=%b halted=%b want 5/1/0", stage, commit_en, halted); end
    @(negedge clk);
    #1;
    checks++; if (stage !== 3'd0) begin errors++; $display("FAIL halt_to_fetch: stage=%0d want 0", stage); end
    run(5, pi, ex, cm, sk);
    checks++; if (ex != 1 || sk != 0 || opcode !== 8'h11)
      begin errors++; $display("FAIL halt_resume: ex=%0d sk=%0d op=%h want 1/0/11", ex, sk, opcode); end
    rst();
    rom[0] = 8'h10; rom[1] = 8'h11;
    halt_req = 1; skip_req = 1;
    run(4, pi, ex, cm, sk);
    halt_req = 0; skip_req = 0;
    #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_prio: halted=%b want 1", halted); end
    wake = 1;
    @(negedge clk);
    wake = 0;
    @(negedge clk);
    run(5, pi, ex, cm, sk);
    checks++; if (ex != 0 || sk == 0 || cm != 1 || pi != 1)
      begin errors++; $display("FAIL halt_skip: ex=%0d sk=%0d cm=%0d pi=%0d want 0/>0/1/1", ex, sk, cm, pi); end
  endtask

  task automatic test_clk_en();
    int pi = 0, ex = 0, cm = 0, viol = 0, hold = 0, n_en = 0, i = 0;
    logic [2:0] prev;
    rst();
    rom[0] = 8'h72; rom[1] = 8'h15;
    while (n_en < 8 && i < 40) begin
      clk_en = (i % 4 == 0) || (i % 4 == 3);
      #1;
      pi += int'(pc_inc); ex += int'(exec_en); cm += int'(commit_en);
      if ((pc_inc | exec_en | commit_en) && !clk_en) viol++;
      prev = stage;
      @(negedge clk);
      if (!clk_en && stage !== prev) hold++;
      n_en += int'(clk_en);
      i++;
    end
    clk_en = 1;
    #1;
    checks++; if (n_en != 8) begin errors++; $display("FAIL gate_budget: %0d enabled cycles want 8", n_en); end
    checks++; if (pi != 2 || ex != 1 || cm != 1 || viol != 0)
      begin errors++; $display("FAIL gate_strobes: pi=%0d ex=%0d cm=%0d viol=%0d want 2/1/1/0", pi, ex, cm, viol); end
    checks++; if (hold != 0) begin errors++; $display("FAIL gate_hold: %0d stage moves while disabled want 0", hold); end
    checks++; if (stage !== 3'd0 || opcode !== 8'h72 || operand !== 8'h15)
      begin errors++; $display("FAIL gate_latch: stage=%0d op=%h opd=%h want 0/72/15", stage, opcode, operand); end
  endtask

  initial begin
    reset_n = 0; pc_clr = 1; clk_en = 0; cpu_id = 0;
    skip_req = 0; skip_lax_req = 0; halt_req = 0; wake = 0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_two_byte();
    test_decode_table();
    test_lax();
    test_halt();
    test_clk_en();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
